// File: rtl/muldiv_execute_unit.sv
// Multi-cycle RISC-V M-extension execute unit. It handles multiply with a fixed
// latency and divide with an iterative restoring divider. It holds one op at a time
// behind a valid/ready handshake, and a flush kills any op in flight.
module muldiv_execute_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_STAGES = 2,
   parameter int unsigned DIV_BITS   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_in,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [4:0]      rd_index_in,
   input  logic [31:0]     program_counter_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      rd_index_out,
   output logic [31:0]     program_counter_out,
   output logic            busy_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int unsigned DIV_ITERS = XLEN / DIV_BITS;
   localparam int unsigned CNT_MAX   = (DIV_ITERS > MUL_STAGES) ? DIV_ITERS : MUL_STAGES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            isrem_q, isrem_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      rd_q, rd_d;
   logic [31:0]     pc_q, pc_d;

   // Operand decode
   logic              mul_a_sgn, mul_b_sgn;
   logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
   logic [XLEN-1:0]   mul_res;
   logic              div_sgn, div_sa, div_sb, div_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b;

   // Divider datapath
   logic [XLEN-1:0] rem_t, quo_t, quo_fix, rem_fix, div_res;
   logic [XLEN:0]   trial;

   assign in_ready            = (state_q == S_IDLE) && !flush_in;
   assign out_valid           = (state_q == S_DONE);
   assign busy_out            = (state_q != S_IDLE);
   assign result_out          = result_q;
   assign rd_index_out        = rd_q;
   assign program_counter_out = pc_q;

   // Decode incoming operands: full-width product and divide magnitudes/special cases
   always_comb begin
      mul_a_sgn = (op_in == 3'd1) || (op_in == 3'd2);
      mul_b_sgn = (op_in == 3'd1);
      mul_a_ext = {{XLEN{mul_a_sgn & rs1_data_in[XLEN-1]}}, rs1_data_in};
      mul_b_ext = {{XLEN{mul_b_sgn & rs2_data_in[XLEN-1]}}, rs2_data_in};
      mul_prod  = mul_a_ext * mul_b_ext;
      mul_res   = (op_in[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

      div_sgn  = !op_in[0];
      div_sa   = div_sgn & rs1_data_in[XLEN-1];
      div_sb   = div_sgn & rs2_data_in[XLEN-1];
      mag_a    = div_sa ? -rs1_data_in : rs1_data_in;
      mag_b    = div_sb ? -rs2_data_in : rs2_data_in;
      div_zero = (rs2_data_in == '0);
      div_ovf  = div_sgn && (rs1_data_in == MIN_NEG) && (rs2_data_in == '1);
   end

   // One divide iteration (DIV_BITS restoring steps) plus the sign-corrected result
   always_comb begin
      rem_t = rem_q;
      quo_t = quo_q;
      trial = '0;
      for (int unsigned i = 0; i < DIV_BITS; i++) begin
         trial = {rem_t, quo_t[XLEN-1]};
         quo_t = {quo_t[XLEN-2:0], 1'b0};
         if (trial >= {1'b0, dvs_q}) begin
            trial    = trial - {1'b0, dvs_q};
            quo_t[0] = 1'b1;
         end
         rem_t = trial[XLEN-1:0];
      end
      quo_fix = qneg_q ? -quo_t : quo_t;
      rem_fix = rneg_q ? -rem_t : rem_t;
      div_res = isrem_q ? rem_fix : quo_fix;
   end

   // Control FSM and next-state datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      isrem_d  = isrem_q;
      result_d = result_q;
      rd_d     = rd_q;
      pc_d     = pc_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               rd_d = rd_index_in;
               pc_d = program_counter_in;
               if (!op_in[2]) begin
                  // Product is formed at accept; the remaining stages only pace the
                  // handshake, so a single-stage multiply goes straight to DONE.
                  result_d = mul_res;
                  if (MUL_STAGES == 1) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_MUL;
                     cnt_d   = CNT_W'(MUL_STAGES - 1);
                  end
               end else if (div_zero) begin
                  result_d = op_in[1] ? rs1_data_in : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = op_in[1] ? '0 : rs1_data_in;
                  state_d  = S_DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = mag_a;
                  dvs_d   = mag_b;
                  qneg_d  = div_sa ^ div_sb;
                  rneg_d  = div_sa;
                  isrem_d = op_in[1];
                  cnt_d   = CNT_W'(DIV_ITERS);
                  state_d = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DIV: begin
            rem_d = rem_t;
            quo_d = quo_t;
            cnt_d = cnt_q - CNT_W'(1);
            // Sign fixup is folded into the edge of the last iteration.
            if (cnt_q == CNT_W'(1)) begin
               result_d = div_res;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (flush_in) begin
         state_d = S_IDLE;
      end
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         isrem_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
         pc_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         isrem_q  <= isrem_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         pc_q     <= pc_d;
      end
   end

endmodule

// File: tb/tb_muldiv_execute_unit.sv
// Scoreboard bench for muldiv_execute_unit. Two instances share the inputs: one
// with default parameters and one with MUL_STAGES=1 and DIV_BITS=4.
module tb_muldiv_execute_unit;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic [31:0] pc;
      int          lat;
      int          drv;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic [2:0]       op;
   logic [31:0]      rs1, rs2;
   logic [4:0]       rd_in;
   logic [31:0]      pc_in;
   logic             out_ready;
   logic [1:0]       ir, ov, busy;
   logic [1:0][31:0] res, pco;
   logic [1:0][4:0]  rdo;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];
   bit [1:0] seen = '0;
   int   first_cyc[2];
   exp_t mon_e;

   muldiv_execute_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) u_dut_a (
      .clk(clk), .rst(rst), .flush_in(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .op_in(op), .rs1_data_in(rs1), .rs2_data_in(rs2), .rd_index_in(rd_in),
      .program_counter_in(pc_in), .out_valid(ov[0]), .out_ready(out_ready),
      .result_out(res[0]), .rd_index_out(rdo[0]), .program_counter_out(pco[0]),
      .busy_out(busy[0]));

   muldiv_execute_unit #(.XLEN(32), .MUL_STAGES(1), .DIV_BITS(4)) u_dut_b (
      .clk(clk), .rst(rst), .flush_in(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .op_in(op), .rs1_data_in(rs1), .rs2_data_in(rs2), .rd_index_in(rd_in),
      .program_counter_in(pc_in), .out_valid(ov[1]), .out_ready(out_ready),
      .result_out(res[1]), .rd_index_out(rdo[1]), .program_counter_out(pco[1]),
      .busy_out(busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, ub;
      logic [63:0] p;
      int          ia, ib;
      logic        ovf;
      ia  = a;
      ib  = b;
      sa  = longint'(ia);
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'd1: begin p = 64'(sa * longint'(ib)); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int mul_st, input int div_it);
      if (!o[2]) return mul_st;
      if (b == 0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return div_it + 1;
   endfunction

   // Present one op for one cycle and queue its expected outcome for each unit
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit pa, input bit pb);
      exp_t e;
      check_eq("in_ready_a", ir[0], 1);
      check_eq("in_ready_b", ir[1], 1);
      rd_in    = 5'($urandom_range(1, 31));
      pc_in    = $urandom;
      op       = o;
      rs1      = a;
      rs2      = b;
      in_valid = 1'b1;
      e.res = exp;
      e.rd  = rd_in;
      e.pc  = pc_in;
      e.drv = cyc;
      e.lat = lat_of(o, a, b, 2, 32);
      if (pa) sb_a.push_back(e);
      e.lat = lat_of(o, a, b, 1, 8);
      if (pb) sb_b.push_back(e);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb_a.size() != 0 || sb_b.size() != 0 || busy != 2'b00) && n < 200) begin
         step();
         n++;
      end
      check_eq("idle_timeout", 64'(n < 200), 1);
   endtask

   // Scoreboard: compare each handshake against the oldest expected entry
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst || flush) begin
            seen[k] = 1'b0;
         end else begin
            if (ov[k] && !seen[k]) begin
               seen[k]      = 1'b1;
               first_cyc[k] = cyc;
            end
            if (ov[k] && out_ready) begin
               seen[k] = 1'b0;
               if ((k == 0 && sb_a.size() == 0) || (k == 1 && sb_b.size() == 0)) begin
                  check_eq($sformatf("spurious_valid_%0d", k), ov[k], 0);
               end else begin
                  if (k == 0) mon_e = sb_a.pop_front();
                  else        mon_e = sb_b.pop_front();
                  check_eq($sformatf("result_%0d", k), res[k], mon_e.res);
                  check_eq($sformatf("rd_%0d", k), rdo[k], mon_e.rd);
                  check_eq($sformatf("pc_%0d", k), pco[k], mon_e.pc);
                  check_eq($sformatf("latency_%0d", k), 64'(first_cyc[k] - mon_e.drv), 64'(mon_e.lat));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  ro;
      int          n;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      rd_in = '0; pc_in = '0; out_ready = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check_eq("rst_in_ready", ir[k], 1);
         check_eq("rst_out_valid", ov[k], 0);
         check_eq("rst_busy", busy[k], 0);
         check_eq("rst_result", res[k], 0);
         check_eq("rst_rd", rdo[k], 0);
         check_eq("rst_pc", pco[k], 0);
      end
      repeat (3) step();
      rst = 1'b1;
      step();

      // Directed vectors
      issue(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 1); wait_idle();
      issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1); wait_idle();
      issue(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1, 1); wait_idle();
      issue(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1, 1); wait_idle();
      issue(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1, 1); wait_idle();
      issue(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1, 1); wait_idle();
      issue(3'd5, 32'd100,        32'd7,         32'd14,        1, 1); wait_idle();
      issue(3'd7, 32'd100,        32'd7,         32'd2,         1, 1); wait_idle();
      issue(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1); wait_idle();
      issue(3'd6, 32'd5,          32'd0,         32'd5,         1, 1); wait_idle();
      issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1); wait_idle();
      issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1); wait_idle();

      // Backpressure: hold the result for 10 cycles, then release
      out_ready = 1'b0;
      issue(3'd5, 32'd100, 32'd7, 32'd14, 1, 1);
      n = 0;
      while (ov != 2'b11 && n < 60) begin step(); n++; end
      check_eq("bp_valid_timeout", 64'(n < 60), 1);
      repeat (10) begin
         step();
         for (int k = 0; k < 2; k++) begin
            check_eq("bp_valid", ov[k], 1);
            check_eq("bp_result", res[k], 32'd14);
            check_eq("bp_in_ready", ir[k], 0);
            check_eq("bp_busy", busy[k], 1);
         end
      end
      out_ready = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         check_eq("bp_release_valid", ov[k], 0);
         check_eq("bp_release_busy", busy[k], 0);
      end
      issue(3'd0, 32'd3, 32'd4, 32'd12, 1, 1); wait_idle();

      // Flush at iteration 10 of the default divider; the fast unit finishes first
      issue(3'd4, 32'd1000, 32'hFFFF_FFFD, model(3'd4, 32'd1000, 32'hFFFF_FFFD), 0, 1);
      repeat (9) step();
      flush = 1'b1; in_valid = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
      step();
      flush = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_eq("flush_busy", busy[k], 0);
         check_eq("flush_valid", ov[k], 0);
      end
      repeat (30) step();
      check_eq("flush_queue_b", 64'(sb_b.size()), 0);
      issue(3'd0, 32'd3, 32'd4, 32'd12, 1, 1); wait_idle();

      // Flush discards a held result even with out_ready high
      out_ready = 1'b0;
      issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
      step();
      check_eq("held_valid_a", ov[0], 1);
      check_eq("held_valid_b", ov[1], 1);
      flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_eq("discard_valid", ov[k], 0);
         check_eq("discard_busy", busy[k], 0);
      end
      repeat (3) step();

      // Asynchronous reset in the middle of a divide
      issue(3'd4, 32'd77777, 32'd3, 32'd0, 0, 0);
      repeat (4) step();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check_eq("arst_valid", ov[k], 0);
         check_eq("arst_busy", busy[k], 0);
         check_eq("arst_result", res[k], 0);
         check_eq("arst_rd", rdo[k], 0);
         check_eq("arst_pc", pco[k], 0);
      end
      repeat (2) step();
      rst = 1'b1;
      step();
      issue(3'd7, 32'd100, 32'd7, 32'd2, 1, 1); wait_idle();

      // Random ops mixed with corner operands
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: ra = 32'd0;
            2: ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         issue(ro, ra, rb, model(ro, ra, rb), 1, 1);
         wait_idle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
